pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the fetch PC and sequences it for the 5-stage MIPS pipeline.
- Each cycle selects the next PC from:
  - sequential PC+4
  - the branch or jump redirect from EX
  - hold, for a load-use hazard, a multiply/divide unit (MDU) busy condition, or halt
- Drives the pipeline stall, IF/ID flush and ID/EX bubble controls.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded while reset is asserted.
- LOAD_STALL_CYCLES, 1, stall length per load-use hazard. Legal range 1..7.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk, input, 1, the single clock; all state updates on posedge.
- reset, input, 1, asynchronous, active-low reset.
- if_id_rs, input, 5, rs of the instruction in ID.
- if_id_rt, input, 5, rt of the instruction in ID.
- id_ex_memread, input, 1, the instruction in EX is a load.
- id_ex_rt, input, 5, destination register of the load in EX.
- id_uses_mdu, input, 1, the instruction in ID reads HI/LO or starts the MDU.
- mdu_busy, input, 1, the MDU is still computing.
- redirect, input, 1, a taken branch or jump was resolved in EX this cycle.
- redirect_target, input, 32, destination of that branch or jump.
- halt_req, input, 1, request to freeze fetch.
- resume, input, 1, leave the halted state.
- pc, output, 32, current fetch PC, registered.
- fetch_valid, output, 1, the instruction at pc is valid to latch into IF/ID.
- stall, output, 1, hold pc and the IF/ID register.
- if_id_flush, output, 1, zero the IF/ID register.
- id_ex_bubble, output, 1, insert a NOP into ID/EX.
- misalign, output, 1, one-cycle pulse when redirect_target[1:0] is not 0.
- stall_count, output, CNT_W, saturating count of stalled cycles.

Behaviour:
- Reset (reset = 0, asynchronous):
  - pc = RESET_PC, state = RUN, load counter = 0, stall_count = 0.
  - stall, if_id_flush, id_ex_bubble and misalign are all 0; fetch_valid = 1.
- States: RUN, LOAD_STALL, MDU_WAIT, HALTED.
- Outputs stall, if_id_flush, id_ex_bubble and misalign are combinational from the current state and inputs (Mealy). pc and all state change only on posedge clk.
- hazard = id_ex_memread && id_ex_rt != 0 && (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt).
- Priority, evaluated each cycle in any state: redirect > halt_req > hazard > (id_uses_mdu && mdu_busy) > normal.
  - Redirect wins because it belongs to the older instruction in EX.
- redirect = 1, any state including HALTED:
  - if_id_flush = 1, id_ex_bubble = 1, stall = 0.
  - Next pc = {redirect_target[31:2], 2'b00}; misalign = |redirect_target[1:0].
  - Next state RUN; the load counter is cleared, aborting any pending stall.
- RUN:
  - halt_req: stall = 1, fetch_valid = 0 combinationally; next state HALTED; pc holds.
  - hazard: stall = 1, id_ex_bubble = 1, pc holds.
    - If LOAD_STALL_CYCLES > 1, go to LOAD_STALL with counter = LOAD_STALL_CYCLES - 1.
    - Otherwise stay in RUN.
  - id_uses_mdu && mdu_busy: stall = 1, id_ex_bubble = 1, pc holds, next state MDU_WAIT.
  - Otherwise: pc <= pc + 4 (32-bit wrap: 32'hFFFF_FFFC goes to 0), stall = 0.
- LOAD_STALL:
  - stall = 1, id_ex_bubble = 1, counter decrements each cycle.
  - When the counter reaches 1, the next state is RUN. Total stall = exactly LOAD_STALL_CYCLES cycles.
- MDU_WAIT:
  - While mdu_busy = 1: stall = 1, id_ex_bubble = 1.
  - The first cycle with mdu_busy = 0 gives stall = 0 and pc <= pc + 4, and the next state is RUN.
- HALTED:
  - stall = 1, fetch_valid = 0, pc holds.
  - resume = 1 gives next state RUN, with fetch_valid = 1 from the next cycle.
  - resume and halt_req both high: halt_req wins and the block stays HALTED.
- stall_count increments on every posedge where stall = 1, in any state including HALTED, and saturates at all-ones.
- Reset asserted mid-stall or mid-halt immediately restores the reset values; there is no partial redirect.

Test Plan:
- Release reset with no hazards for 5 cycles -> pc = 0, 4, 8, 12, 16; stall = 0; fetch_valid = 1.
- id_ex_memread = 1, id_ex_rt = 5, if_id_rs = 5, LOAD_STALL_CYCLES = 1 -> exactly 1 cycle with stall = 1 and id_ex_bubble = 1, pc held, stall_count = 1. Repeat with id_ex_rt = 0 -> no stall.
- LOAD_STALL_CYCLES = 3 with a hazard, then redirect = 1 to 32'h0000_0400 on the second stall cycle -> if_id_flush = 1, next pc = 0x400, state RUN, total stall cycles = 2.
- id_uses_mdu = 1 with mdu_busy high for 4 cycles -> stall for 4 cycles, pc advances by 4 in the cycle mdu_busy falls.
- halt_req pulse, then resume and halt_req high together, then resume alone -> stays HALTED with fetch_valid = 0 until the lone resume; next cycle fetch_valid = 1 and pc resumes incrementing.
- redirect_target = 32'h0000_1002 -> pc = 0x1000, misalign pulses for one cycle. Separately, force pc = 32'hFFFF_FFFC via a redirect, then run -> pc wraps to 0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-PC sequencer bundle: hazard/redirect/halt inputs from the pipeline
// and the PC, stall and flush controls back to it.
interface pc_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       if_id_rs;
  logic [4:0]       if_id_rt;
  logic             id_ex_memread;
  logic [4:0]       id_ex_rt;
  logic             id_uses_mdu;
  logic             mdu_busy;
  logic             redirect;
  logic [31:0]      redirect_target;
  logic             halt_req;
  logic             resume;
  logic [31:0]      pc;
  logic             fetch_valid;
  logic             stall;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             misalign;
  logic [CNT_W-1:0] stall_count;

  // The pipeline side drives hazard/redirect information and consumes controls.
  modport master (
    output if_id_rs, if_id_rt, id_ex_memread, id_ex_rt, id_uses_mdu, mdu_busy,
           redirect, redirect_target, halt_req, resume,
    input  pc, fetch_valid, stall, if_id_flush, id_ex_bubble, misalign, stall_count
  );

  modport slave (
    input  if_id_rs, if_id_rt, id_ex_memread, id_ex_rt, id_uses_mdu, mdu_busy,
           redirect, redirect_target, halt_req, resume,
    output pc, fetch_valid, stall, if_id_flush, id_ex_bubble, misalign, stall_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC owner for the 5-stage MIPS pipeline: selects PC+4, EX redirect or
// hold (load-use, MDU busy, halt) and drives stall/flush/bubble controls.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC          = 32'h0000_0000,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 16
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MDU_WAIT   = 2'd2,
    HALTED     = 2'd3
  } state_e;

  localparam bit         MULTI_STALL = (LOAD_STALL_CYCLES > 1);
  localparam logic [2:0] LOAD_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       lcnt_q, lcnt_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic hazard;
  logic stall, flush, bubble, fetch_valid, misalign;

  assign hazard = bus.id_ex_memread && (bus.id_ex_rt != 5'd0) &&
                  ((bus.id_ex_rt == bus.if_id_rs) || (bus.id_ex_rt == bus.if_id_rt));

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    lcnt_d      = lcnt_q;
    pc_d        = pc_q;
    stall       = 1'b0;
    flush       = 1'b0;
    bubble      = 1'b0;
    fetch_valid = 1'b1;
    misalign    = 1'b0;

    // The redirect belongs to the older instruction in EX, so it overrides
    // any hold, including a halt or a pending load stall.
    if (bus.redirect) begin
      flush    = 1'b1;
      bubble   = 1'b1;
      pc_d     = {bus.redirect_target[31:2], 2'b00};
      misalign = |bus.redirect_target[1:0];
      state_d  = RUN;
      lcnt_d   = 3'd0;
    end else if (bus.halt_req) begin
      stall       = 1'b1;
      fetch_valid = 1'b0;
      state_d     = HALTED;
      lcnt_d      = 3'd0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (hazard) begin
            stall  = 1'b1;
            bubble = 1'b1;
            if (MULTI_STALL) begin
              state_d = LOAD_STALL;
              lcnt_d  = LOAD_RELOAD;
            end
          end else if (bus.id_uses_mdu && bus.mdu_busy) begin
            stall   = 1'b1;
            bubble  = 1'b1;
            state_d = MDU_WAIT;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
        LOAD_STALL: begin
          stall  = 1'b1;
          bubble = 1'b1;
          lcnt_d = lcnt_q - 3'd1;
          if (lcnt_q <= 3'd1) begin
            state_d = RUN;
          end
        end
        MDU_WAIT: begin
          if (bus.mdu_busy) begin
            stall  = 1'b1;
            bubble = 1'b1;
          end else begin
            pc_d    = pc_q + 32'd4;
            state_d = RUN;
          end
        end
        HALTED: begin
          stall       = 1'b1;
          fetch_valid = 1'b0;
          if (bus.resume) begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      lcnt_q      <= 3'd0;
      pc_q        <= RESET_PC;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      pc_q    <= pc_d;
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.pc           = pc_q;
  assign bus.fetch_valid  = fetch_valid;
  assign bus.stall        = stall;
  assign bus.if_id_flush  = flush;
  assign bus.id_ex_bubble = bubble;
  assign bus.misalign     = misalign;
  assign bus.stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (1- and 3-cycle load stall, 16- and
// 4-bit counters) driven identically and compared against a flag-based model.
module tb_pc_sequencer;

  localparam logic [31:0] RPC_A = 32'h0000_0000;
  localparam logic [31:0] RPC_B = 32'h0000_0100;

  typedef struct {
    logic [31:0] pc;
    bit          halted;
    bit          mdu_wait;
    int          stall_left;
    int unsigned cnt;
  } model_t;

  typedef struct {
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        bubble;
    logic        fv;
    logic        mis;
    logic [31:0] cnt;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs, rt, ex_rt;
  logic        memread, uses, busy, redirect, halt_req, resume;
  logic [31:0] target;

  int checks   = 0;
  int failures = 0;

  model_t      m [2];
  int          lcyc [2] = '{1, 3};
  int unsigned cmax [2] = '{65535, 15};
  logic [31:0] rpc  [2] = '{RPC_A, RPC_B};
  string       nm   [2] = '{"a", "b"};

  always #5 clk = ~clk;

  pc_sequencer_if #(.CNT_W(16)) bus_a ();
  pc_sequencer_if #(.CNT_W(4))  bus_b ();

  pc_sequencer #(.RESET_PC(RPC_A), .LOAD_STALL_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );
  pc_sequencer #(.RESET_PC(RPC_B), .LOAD_STALL_CYCLES(3), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  assign bus_a.if_id_rs = rs;          assign bus_b.if_id_rs = rs;
  assign bus_a.if_id_rt = rt;          assign bus_b.if_id_rt = rt;
  assign bus_a.id_ex_memread = memread; assign bus_b.id_ex_memread = memread;
  assign bus_a.id_ex_rt = ex_rt;       assign bus_b.id_ex_rt = ex_rt;
  assign bus_a.id_uses_mdu = uses;     assign bus_b.id_uses_mdu = uses;
  assign bus_a.mdu_busy = busy;        assign bus_b.mdu_busy = busy;
  assign bus_a.redirect = redirect;    assign bus_b.redirect = redirect;
  assign bus_a.redirect_target = target; assign bus_b.redirect_target = target;
  assign bus_a.halt_req = halt_req;    assign bus_b.halt_req = halt_req;
  assign bus_a.resume = resume;        assign bus_b.resume = resume;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic get_obs(input int i, output obs_t o);
    if (i == 0) begin
      o.pc = bus_a.pc; o.stall = bus_a.stall; o.flush = bus_a.if_id_flush;
      o.bubble = bus_a.id_ex_bubble; o.fv = bus_a.fetch_valid; o.mis = bus_a.misalign;
      o.cnt = 32'(bus_a.stall_count);
    end else begin
      o.pc = bus_b.pc; o.stall = bus_b.stall; o.flush = bus_b.if_id_flush;
      o.bubble = bus_b.id_ex_bubble; o.fv = bus_b.fetch_valid; o.mis = bus_b.misalign;
      o.cnt = 32'(bus_b.stall_count);
    end
  endtask

  // One cycle of the pipeline's PC rules, written as pending-work flags.
  function automatic void model_step(input model_t s, input int l, input int unsigned cm,
                                     output obs_t e, output model_t n);
    bit hz;
    n = s;
    e.pc = s.pc; e.cnt = s.cnt;
    e.stall = 0; e.flush = 0; e.bubble = 0; e.fv = 1; e.mis = 0;
    hz = memread && (ex_rt != 0) && (ex_rt == rs || ex_rt == rt);
    if (redirect) begin
      e.flush = 1; e.bubble = 1; e.mis = (target % 4) != 0;
      n.pc = target - (target % 4);
      n.halted = 0; n.mdu_wait = 0; n.stall_left = 0;
    end else if (halt_req) begin
      e.stall = 1; e.fv = 0;
      n.halted = 1; n.mdu_wait = 0; n.stall_left = 0;
    end else if (s.halted) begin
      e.stall = 1; e.fv = 0;
      if (resume) n.halted = 0;
    end else if (s.stall_left > 0) begin
      e.stall = 1; e.bubble = 1; n.stall_left = s.stall_left - 1;
    end else if (s.mdu_wait) begin
      if (busy) begin
        e.stall = 1; e.bubble = 1;
      end else begin
        n.pc = s.pc + 32'd4; n.mdu_wait = 0;
      end
    end else if (hz) begin
      e.stall = 1; e.bubble = 1; n.stall_left = l - 1;
    end else if (uses && busy) begin
      e.stall = 1; e.bubble = 1; n.mdu_wait = 1;
    end else begin
      n.pc = s.pc + 32'd4;
    end
    if (e.stall && s.cnt < cm) n.cnt = s.cnt + 1;
  endfunction

  task automatic cyc();
    obs_t   e [2];
    obs_t   o;
    model_t n [2];
    #1;
    for (int i = 0; i < 2; i++) begin
      model_step(m[i], lcyc[i], cmax[i], e[i], n[i]);
      get_obs(i, o);
      check({nm[i], " pc"}, o.pc, e[i].pc);
      check({nm[i], " stall"}, 32'(o.stall), 32'(e[i].stall));
      check({nm[i], " flush"}, 32'(o.flush), 32'(e[i].flush));
      check({nm[i], " bubble"}, 32'(o.bubble), 32'(e[i].bubble));
      check({nm[i], " fetch_valid"}, 32'(o.fv), 32'(e[i].fv));
      check({nm[i], " misalign"}, 32'(o.mis), 32'(e[i].mis));
      check({nm[i], " stall_count"}, o.cnt, e[i].cnt);
    end
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic check_reset_state();
    obs_t o;
    for (int i = 0; i < 2; i++) begin
      get_obs(i, o);
      check({nm[i], " rst pc"}, o.pc, rpc[i]);
      check({nm[i], " rst stall"}, 32'(o.stall), 32'd0);
      check({nm[i], " rst flush"}, 32'(o.flush), 32'd0);
      check({nm[i], " rst bubble"}, 32'(o.bubble), 32'd0);
      check({nm[i], " rst misalign"}, 32'(o.mis), 32'd0);
      check({nm[i], " rst fetch_valid"}, 32'(o.fv), 32'd1);
      check({nm[i], " rst stall_count"}, o.cnt, 32'd0);
      m[i] = '{pc: rpc[i], halted: 0, mdu_wait: 0, stall_left: 0, cnt: 0};
    end
  endtask

  task automatic idle();
    rs = 0; rt = 0; ex_rt = 0; memread = 0; uses = 0; busy = 0;
    redirect = 0; target = 0; halt_req = 0; resume = 0;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    reset = 1'b1;

    // Free-running fetch from reset.
    repeat (5) cyc();
    check("a pc after 5", bus_a.pc, 32'd20);

    // Load-use hazard for one cycle, then a non-hazard on r0.
    memread = 1; ex_rt = 5; rs = 5;
    cyc();
    idle();
    cyc(); cyc();
    check("a cnt load-use", 32'(bus_a.stall_count), 32'd1);
    check("b cnt load-use", 32'(bus_b.stall_count), 32'd3);
    memread = 1; ex_rt = 0; rs = 0; rt = 0;
    cyc();
    check("a cnt r0 no stall", 32'(bus_a.stall_count), 32'd1);

    // Hazard, then a redirect that aborts the 3-cycle stall after two cycles.
    memread = 1; ex_rt = 7; rt = 7; rs = 2;
    cyc();
    idle();
    cyc();
    redirect = 1; target = 32'h0000_0400;
    cyc();
    check("b pc redirect", bus_b.pc, 32'h0000_0400);
    check("b cnt aborted stall", 32'(bus_b.stall_count), 32'd5);

    // MDU busy for four cycles.
    idle();
    uses = 1; busy = 1;
    repeat (4) cyc();
    busy = 0;
    cyc();
    idle();
    check("a pc after mdu", bus_a.pc, 32'h0000_0404);
    check("a cnt after mdu", 32'(bus_a.stall_count), 32'd6);

    // Halt, then resume with halt_req (halt wins), then resume alone.
    halt_req = 1; cyc();
    halt_req = 0; cyc();
    halt_req = 1; resume = 1; cyc();
    check("a fv halt+resume", 32'(bus_a.fetch_valid), 32'd0);
    halt_req = 0; resume = 1; cyc();
    resume = 0;
    #1;
    check("a fv after resume", 32'(bus_a.fetch_valid), 32'd1);
    check("a pc held in halt", bus_a.pc, 32'h0000_0404);
    cyc();
    check("a pc resumes", bus_a.pc, 32'h0000_0408);

    // Misaligned redirect, then wrap at the top of the address space.
    redirect = 1; target = 32'h0000_1002;
    #1;
    check("a misalign pulse", 32'(bus_a.misalign), 32'd1);
    cyc();
    redirect = 0;
    cyc();
    check("b pc aligned", bus_b.pc, 32'h0000_1004);
    redirect = 1; target = 32'hFFFF_FFFC;
    cyc();
    redirect = 0;
    cyc();
    check("a pc wrap", bus_a.pc, 32'h0000_0000);

    // Reset asserted in the middle of a halt.
    halt_req = 1; cyc();
    halt_req = 0;
    #2;
    reset = 1'b0;
    #1;
    check_reset_state();
    @(negedge clk);
    reset = 1'b1;

    // Random traffic, including counter saturation on the narrow instance.
    for (int k = 0; k < 3000; k++) begin
      rs       = 5'($urandom_range(0, 3));
      rt       = 5'($urandom_range(0, 3));
      ex_rt    = 5'($urandom_range(0, 3));
      memread  = ($urandom_range(0, 3) == 0);
      uses     = ($urandom_range(0, 1) == 1);
      busy     = ($urandom_range(0, 2) != 0);
      redirect = ($urandom_range(0, 15) == 0);
      target   = $urandom;
      halt_req = ($urandom_range(0, 19) == 0);
      resume   = ($urandom_range(0, 3) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
